freq_step_ctrl: RTL and testbench



---
 rtl/freq_step_ctrl.sv | 147 ++++++++++++++
 tb/tb_freq_step_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_step_ctrl.sv
// Plus/Minus button front end: sync, debounce, arbitration and hold-to-repeat
// stepping of the saturating 6-bit frequency Scale register.
module freq_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_RATE     = 10000,
    parameter int SCALE_RESET     = 32,
    parameter int SCALE_MIN       = 0,
    parameter int SCALE_MAX       = 63
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       Plus,
    input  logic       Minus,
    output logic [5:0] Scale,
    output logic       Step_up,
    output logic       Step_down,
    output logic       At_min,
    output logic       At_max
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] REPEAT  = 2'd2;
    localparam logic [1:0] LOCKOUT = 2'd3;

    // bit 0 = Plus, bit 1 = Minus
    logic [1:0]    s1, s2, deb, deb_q;
    logic [DW-1:0] cnt [2];

    logic [1:0]    state, state_nxt;
    logic          own, own_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic          step, step_up_dir;
    logic [5:0]    scale_nxt;
    logic          up_ok, dn_ok;
    logic          p_rise, m_rise, own_lvl, oth_lvl;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            s1    <= {Minus, Plus};
            s2    <= s1;
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else if (s2[i] != deb[i]) begin
                    cnt[i] <= cnt[i] + DW'(1);
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign p_rise  = deb[0] & ~deb_q[0];
    assign m_rise  = deb[1] & ~deb_q[1];
    assign own_lvl = own ? deb[0] : deb[1];
    assign oth_lvl = own ? deb[1] : deb[0];

    always_comb begin
        state_nxt   = state;
        own_nxt     = own;
        rcnt_nxt    = rcnt;
        step        = 1'b0;
        step_up_dir = own;
        unique case (state)
            IDLE: begin
                if (p_rise && m_rise) begin
                    state_nxt = LOCKOUT;
                end else if (p_rise || m_rise) begin
                    step        = 1'b1;
                    step_up_dir = p_rise;
                    own_nxt     = p_rise;
                    rcnt_nxt    = '0;
                    state_nxt   = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (!own_lvl) begin
                    state_nxt = IDLE;
                end else if (oth_lvl) begin
                    state_nxt = LOCKOUT;
                end else if ((state == HOLD && rcnt == RW'(REPEAT_DELAY - 1)) ||
                             (state == REPEAT && rcnt == RW'(REPEAT_RATE - 1))) begin
                    step      = 1'b1;
                    rcnt_nxt  = '0;
                    state_nxt = REPEAT;
                end else begin
                    rcnt_nxt = rcnt + RW'(1);
                end
            end
            LOCKOUT: begin
                if (deb == 2'b00) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A step at the bound is swallowed here; the FSM still advances.
    always_comb begin
        scale_nxt = Scale;
        up_ok     = 1'b0;
        dn_ok     = 1'b0;
        if (step && step_up_dir && Scale != 6'(SCALE_MAX)) begin
            scale_nxt = Scale + 6'd1;
            up_ok     = 1'b1;
        end else if (step && !step_up_dir && Scale != 6'(SCALE_MIN)) begin
            scale_nxt = Scale - 6'd1;
            dn_ok     = 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state     <= IDLE;
            own       <= 1'b0;
            rcnt      <= '0;
            Scale     <= 6'(SCALE_RESET);
            Step_up   <= 1'b0;
            Step_down <= 1'b0;
            At_min    <= (SCALE_RESET == SCALE_MIN);
            At_max    <= (SCALE_RESET == SCALE_MAX);
        end else begin
            state     <= state_nxt;
            own       <= own_nxt;
            rcnt      <= rcnt_nxt;
            Scale     <= scale_nxt;
            Step_up   <= up_ok;
            Step_down <= dn_ok;
            At_min    <= (scale_nxt == 6'(SCALE_MIN));
            At_max    <= (scale_nxt == 6'(SCALE_MAX));
        end
    end

endmodule

// File: tb/tb_freq_step_ctrl.sv
// Randomised and directed bench for freq_step_ctrl against a
// time-based reference model of debounce windows and step schedule.
module tb_freq_step_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Plus = 1'b0;
    logic       Minus = 1'b0;
    logic [5:0] Scale;
    logic       Step_up, Step_down, At_min, At_max;

    freq_step_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .sysclk(clk),
        .reset(reset),
        .Plus(Plus),
        .Minus(Minus),
        .Scale(Scale),
        .Step_up(Step_up),
        .Step_down(Step_down),
        .At_min(At_min),
        .At_max(At_max)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int ecount = 0;
    int up_q[$];
    int dn_q[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // reference model state
    int hist_p[$];
    int hist_m[$];
    int mst = 0;
    bit mown = 0;
    int mlast = 0;
    bit md[2] = '{0, 0};
    bit mdq[2] = '{0, 0};
    int mflip[2] = '{0, 0};
    int mscale = 32;
    bit eup = 0;
    bit edn = 0;

    // true when the last DB synchronised samples all disagree with lvl
    function automatic bit win_ok(input int b, input bit lvl);
        int idx;
        int v;
        for (int j = 3; j <= DB + 2; j++) begin
            idx = (b == 0 ? hist_p.size() : hist_m.size()) - 1 - j;
            if (idx < 0) v = 0;
            else v = (b == 0) ? hist_p[idx] : hist_m[idx];
            if (v == int'(lvl)) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        int e;
        bit st, up, own_l, oth_l, r0, r1;
        e = ecount;
        ecount++;
        st = 0;
        up = 0;
        if (reset) begin
            hist_p.delete();
            hist_m.delete();
            hist_p.push_back(0);
            hist_m.push_back(0);
            mscale = 32;
            eup = 0;
            edn = 0;
            mst = 0;
            mown = 0;
            md = '{0, 0};
            mdq = '{0, 0};
            mflip = '{e, e};
        end else begin
            hist_p.push_back(int'(Plus));
            hist_m.push_back(int'(Minus));
            r0 = md[0] && !mdq[0];
            r1 = md[1] && !mdq[1];
            own_l = mown ? md[0] : md[1];
            oth_l = mown ? md[1] : md[0];
            case (mst)
                0: begin
                    if (r0 && r1) mst = 3;
                    else if (r0 || r1) begin
                        st = 1; up = r0; mown = r0; mst = 1; mlast = e;
                    end
                end
                1, 2: begin
                    if (!own_l) mst = 0;
                    else if (oth_l) mst = 3;
                    else if (e - mlast == (mst == 1 ? RD : RR)) begin
                        st = 1; up = mown; mst = 2; mlast = e;
                    end
                end
                default: if (!md[0] && !md[1]) mst = 0;
            endcase
            eup = st && up && mscale < 63;
            edn = st && !up && mscale > 0;
            if (eup) mscale++;
            if (edn) mscale--;
            for (int b = 0; b < 2; b++) begin
                mdq[b] = md[b];
                if (e - mflip[b] >= DB + 1 && win_ok(b, md[b])) begin
                    md[b] = !md[b];
                    mflip[b] = e;
                end
            end
        end
        #1;
        chk("scale", Scale, mscale);
        chk("step_up", Step_up, eup);
        chk("step_down", Step_down, edn);
        chk("at_min", At_min, mscale == 0);
        chk("at_max", At_max, mscale == 63);
        if (Step_up) up_q.push_back(e);
        if (Step_down) dn_q.push_back(e);
    end

    task automatic run(input logic p, input logic m, input int n);
        Plus = p;
        Minus = m;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    int s;
    int ex[5] = '{7, 27, 35, 43, 51};
    int r;

    initial begin
        @(negedge clk);
        do_reset(3);
        run(0, 0, 10);
        chk("rst_scale", Scale, 32);
        chk("rst_min", At_min, 0);
        chk("rst_max", At_max, 0);

        up_q.delete();
        s = ecount;
        run(1, 0, 10);
        run(0, 0, 20);
        chk("single_scale", Scale, 33);
        chk("single_cnt", up_q.size(), 1);
        chk("single_edge", up_q.size() > 0 ? up_q[0] - s : -1, 7);

        do_reset(2);
        up_q.delete();
        dn_q.delete();
        run(1, 0, 3);
        run(0, 0, 10);
        for (int i = 0; i < 40; i++) run(0, logic'(i % 2), 1);
        run(0, 0, 20);
        chk("glitch_scale", Scale, 32);
        chk("glitch_pulses", up_q.size() + dn_q.size(), 0);

        up_q.delete();
        s = ecount;
        run(1, 0, 50);
        run(0, 0, 30);
        chk("rep_cnt", up_q.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("rep_edge", i < up_q.size() ? up_q[i] - s : -1, ex[i]);
        chk("rep_scale", Scale, 37);

        for (int i = 0; i < 25; i++) begin
            run(1, 0, 8);
            run(0, 0, 12);
        end
        chk("preload", Scale, 62);
        up_q.delete();
        run(1, 0, 60);
        run(0, 0, 20);
        chk("sat_cnt", up_q.size(), 1);
        chk("sat_scale", Scale, 63);
        chk("sat_max", At_max, 1);
        run(0, 1, 700);
        run(0, 0, 20);
        chk("min_scale", Scale, 0);
        chk("min_flag", At_min, 1);

        do_reset(2);
        up_q.delete();
        dn_q.delete();
        run(1, 1, 30);
        run(0, 0, 20);
        chk("lock_pulses", up_q.size() + dn_q.size(), 0);
        chk("lock_scale", Scale, 32);
        run(0, 1, 10);
        run(0, 0, 20);
        chk("after_lock", Scale, 31);
        chk("after_lock_cnt", dn_q.size(), 1);

        do_reset(2);
        run(1, 0, 44);
        chk("pre_rst", Scale, 36);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst", Scale, 32);
        reset = 1'b0;
        up_q.delete();
        s = ecount;
        run(1, 0, 20);
        run(0, 0, 20);
        chk("rst_hold_edge", up_q.size() > 0 ? up_q[0] - s : -1, 7);

        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) do_reset(int'($urandom_range(1, 3)));
            else if (r < 8) run(1, 0, int'($urandom_range(1, 60)));
            else if (r < 15) run(0, 1, int'($urandom_range(1, 60)));
            else if (r < 17) run(1, 1, int'($urandom_range(1, 20)));
            else run(0, 0, int'($urandom_range(1, 15)));
        end
        run(0, 0, 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
